// File: rtl/fakeram7_dp_arbiter.sv
// Round-robin arbiter sharing one dual-port fakeram7 macro among NUM_REQ requesters.
// Grants up to two non-conflicting requests per cycle and steers read data back one cycle later.
module fakeram7_dp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int BITS       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ-1:0]            req_we_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQ*BITS-1:0]       req_wd_in,
    input  logic [NUM_REQ*BITS-1:0]       req_mask_in,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    output logic [NUM_REQ*BITS-1:0]       rsp_data_out,
    output logic                          ram_ce_out,
    output logic [ADDR_WIDTH-1:0]         ram_addr_A_out,
    output logic [ADDR_WIDTH-1:0]         ram_addr_B_out,
    output logic                          ram_we_A_out,
    output logic                          ram_we_B_out,
    output logic [BITS-1:0]               ram_wd_A_out,
    output logic [BITS-1:0]               ram_wd_B_out,
    output logic [BITS-1:0]               ram_mask_A_out,
    output logic [BITS-1:0]               ram_mask_B_out,
    input  logic [BITS-1:0]               ram_rd_A_in,
    input  logic [BITS-1:0]               ram_rd_B_in
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         rr_ptr;
    logic                  rd_pend_a, rd_pend_b;
    logic [PW-1:0]         own_a, own_b;
    logic                  gnt_a, gnt_b;
    logic [PW-1:0]         idx_a, idx_b, scan_idx;
    logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
    logic [BITS-1:0]       wd   [NUM_REQ];
    logic [BITS-1:0]       mask [NUM_REQ];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NUM_REQ - 1))
            return '0;
        return v + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr[i] = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            wd[i]   = req_wd_in[i*BITS +: BITS];
            mask[i] = req_mask_in[i*BITS +: BITS];
        end
    end

    // Port B skips any candidate touching A's address unless both are reads.
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        idx_a    = '0;
        idx_b    = '0;
        scan_idx = rr_ptr;
        if (rst_n_in) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (req_valid_in[scan_idx]) begin
                    if (!gnt_a) begin
                        gnt_a = 1'b1;
                        idx_a = scan_idx;
                    end else if (!gnt_b &&
                                 !((addr[scan_idx] == addr[idx_a]) &&
                                   (req_we_in[scan_idx] || req_we_in[idx_a]))) begin
                        gnt_b = 1'b1;
                        idx_b = scan_idx;
                    end
                end
                scan_idx = wrap_inc(scan_idx);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++)
            req_ready_out[i] = (gnt_a && idx_a == PW'(i)) || (gnt_b && idx_b == PW'(i));
        ram_ce_out     = gnt_a || gnt_b;
        ram_addr_A_out = gnt_a ? addr[idx_a]         : '0;
        ram_we_A_out   = gnt_a ? req_we_in[idx_a]    : 1'b0;
        ram_wd_A_out   = gnt_a ? wd[idx_a]           : '0;
        ram_mask_A_out = gnt_a ? mask[idx_a]         : '0;
        ram_addr_B_out = gnt_b ? addr[idx_b]         : '0;
        ram_we_B_out   = gnt_b ? req_we_in[idx_b]    : 1'b0;
        ram_wd_B_out   = gnt_b ? wd[idx_b]           : '0;
        ram_mask_B_out = gnt_b ? mask[idx_b]         : '0;
    end

    always_comb begin
        rsp_valid_out = '0;
        rsp_data_out  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rd_pend_a && own_a == PW'(i)) begin
                rsp_valid_out[i]            = 1'b1;
                rsp_data_out[i*BITS +: BITS] = ram_rd_A_in;
            end
            if (rd_pend_b && own_b == PW'(i)) begin
                rsp_valid_out[i]            = 1'b1;
                rsp_data_out[i*BITS +: BITS] = ram_rd_B_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr    <= '0;
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
            own_a     <= '0;
            own_b     <= '0;
        end else begin
            rd_pend_a <= gnt_a && !req_we_in[idx_a];
            rd_pend_b <= gnt_b && !req_we_in[idx_b];
            if (gnt_a && !req_we_in[idx_a])
                own_a <= idx_a;
            if (gnt_b && !req_we_in[idx_b])
                own_b <= idx_b;
            if (gnt_b)
                rr_ptr <= wrap_inc(idx_b);
            else if (gnt_a)
                rr_ptr <= wrap_inc(idx_a);
        end
    end

endmodule

// File: tb/tb_fakeram7_dp_arbiter.sv
// Directed bench for fakeram7_dp_arbiter with a behavioural dual-port masked-write RAM
// (registered read) standing in for the fakeram7 macro.
module tb_fakeram7_dp_arbiter;

    localparam int NR = 4;
    localparam int AW = 13;
    localparam int BW = 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*BW-1:0]  req_wd;
    logic [NR*BW-1:0]  req_mask;
    logic [NR-1:0]     rsp_valid;
    logic [NR*BW-1:0]  rsp_data;
    logic              ram_ce;
    logic [AW-1:0]     ram_addr_a, ram_addr_b;
    logic              ram_we_a, ram_we_b;
    logic [BW-1:0]     ram_wd_a, ram_wd_b, ram_mask_a, ram_mask_b;
    logic [BW-1:0]     ram_rd_a, ram_rd_b;

    logic [BW-1:0]     mem [1 << AW];
    int                tests;
    int                fails;

    fakeram7_dp_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .BITS(BW)) dut (
        .clk            (clk),
        .rst_n_in       (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_we_in      (req_we),
        .req_addr_in    (req_addr),
        .req_wd_in      (req_wd),
        .req_mask_in    (req_mask),
        .rsp_valid_out  (rsp_valid),
        .rsp_data_out   (rsp_data),
        .ram_ce_out     (ram_ce),
        .ram_addr_A_out (ram_addr_a),
        .ram_addr_B_out (ram_addr_b),
        .ram_we_A_out   (ram_we_a),
        .ram_we_B_out   (ram_we_b),
        .ram_wd_A_out   (ram_wd_a),
        .ram_wd_B_out   (ram_wd_b),
        .ram_mask_A_out (ram_mask_a),
        .ram_mask_B_out (ram_mask_b),
        .ram_rd_A_in    (ram_rd_a),
        .ram_rd_B_in    (ram_rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we_a)
                mem[ram_addr_a] = (mem[ram_addr_a] & ~ram_mask_a) | (ram_wd_a & ram_mask_a);
            else
                ram_rd_a <= mem[ram_addr_a];
            if (ram_we_b)
                mem[ram_addr_b] = (mem[ram_addr_b] & ~ram_mask_b) | (ram_wd_b & ram_mask_b);
            else
                ram_rd_b <= mem[ram_addr_b];
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [BW-1:0] d, input logic [BW-1:0] m);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wd[i*BW +: BW]   = d;
        req_mask[i*BW +: BW] = m;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wd    = '0;
        req_mask  = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [159:0] ram_outs();
        return {3'b0, ram_ce, ram_addr_a, ram_addr_b, ram_we_a, ram_we_b,
                ram_wd_a, ram_wd_b, ram_mask_a, ram_mask_b};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        ram_rd_a = '0;
        ram_rd_b = '0;
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = '0;
        clr_all();
        rst_n = 1'b0;

        // Reset holds every output low even with all requesters valid
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b1, 13'h0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #2;
        check("reset_ready", {156'b0, req_ready}, 160'h0);
        check("reset_ram", ram_outs(), 160'h0);
        check("reset_rsp", {28'b0, rsp_valid, rsp_data}, 160'h0);
        step();
        clr_all();
        rst_n = 1'b1;

        // Single requester write then read
        step();
        set_req(0, 1'b1, 13'h0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        #1;
        check("wr0_ready", {156'b0, req_ready}, 160'h1);
        check("wr0_ram", ram_outs(),
              {3'b0, 1'b1, 13'h0010, 13'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h0});
        step();
        clr_all();
        set_req(0, 1'b0, 13'h0010, 32'h0, 32'h0);
        #1;
        check("rd0_ready", {156'b0, req_ready}, 160'h1);
        check("rd0_rsp_early", {156'b0, rsp_valid}, 160'h0);
        step();
        clr_all();
        #1;
        check("rd0_rsp_valid", {156'b0, rsp_valid}, 160'h1);
        check("rd0_rsp_data", {32'b0, rsp_data}, {128'h0, 32'hDEAD_BEEF});
        check("idle_ram", ram_outs(), 160'h0);
        step();
        check("rsp_one_pulse", {156'b0, rsp_valid}, 160'h0);

        // Masked write over existing data at top address
        set_req(0, 1'b1, 13'h1FFF, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        step();
        set_req(0, 1'b1, 13'h1FFF, 32'h1234_5678, 32'h0000_FFFF);
        #1;
        check("mask_wr_ram", ram_outs(),
              {3'b0, 1'b1, 13'h1FFF, 13'h0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0000_FFFF, 32'h0});
        step();
        set_req(0, 1'b0, 13'h1FFF, 32'h0, 32'h0);
        step();
        clr_all();
        #1;
        check("mask_rd_data", {28'b0, rsp_valid, rsp_data}, {28'b0, 4'b0001, 96'h0, 32'hAAAA_5678});

        // Preload 0x20..0x23 one requester at a time; ends with rr_ptr back at 0
        for (int i = 0; i < NR; i++) begin
            step();
            clr_all();
            set_req(i, 1'b1, 13'(32'h20 + i), 32'hC0DE_0000 + i, 32'hFFFF_FFFF);
        end
        step();
        clr_all();

        // Read by requester 2 then reset mid-flight: pulse dropped, rr_ptr cleared
        set_req(2, 1'b0, 13'h0022, 32'h0, 32'h0);
        #1;
        check("pre_rst_ready", {156'b0, req_ready}, 160'h4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clr_all();
        step();
        check("rst_drop_rsp", {28'b0, rsp_valid, rsp_data}, 160'h0);
        rst_n = 1'b1;

        // All four continuously reading distinct addresses from rr_ptr 0
        step();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b0, 13'(32'h20 + i), 32'h0, 32'h0);
        #1;
        check("rr_c0_ready", {156'b0, req_ready}, 160'h3);
        check("rr_c0_addr", {134'b0, ram_addr_a, ram_addr_b}, {134'b0, 13'h20, 13'h21});
        step();
        check("rr_c1_ready", {156'b0, req_ready}, 160'hC);
        check("rr_c1_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b0011, 32'h0, 32'h0, 32'hC0DE_0001, 32'hC0DE_0000});
        step();
        check("rr_c2_ready", {156'b0, req_ready}, 160'h3);
        check("rr_c2_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b1100, 32'hC0DE_0003, 32'hC0DE_0002, 32'h0, 32'h0});
        step();
        clr_all();
        #1;
        check("rr_c3_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b0011, 32'h0, 32'h0, 32'hC0DE_0001, 32'hC0DE_0000});

        // Requester 3 writes 0x200 alone so rr_ptr wraps to 0
        set_req(3, 1'b1, 13'h0200, 32'h0BAD_F00D, 32'hFFFF_FFFF);
        step();
        clr_all();

        // Conflict: write 0x100 by 0 blocks read 0x100 by 1 this cycle
        set_req(0, 1'b1, 13'h0100, 32'h55AA_55AA, 32'hFFFF_FFFF);
        set_req(1, 1'b0, 13'h0100, 32'h0, 32'h0);
        set_req(2, 1'b0, 13'h0200, 32'h0, 32'h0);
        #1;
        check("cf_ready", {156'b0, req_ready}, 160'h5);
        check("cf_ram", ram_outs(),
              {3'b0, 1'b1, 13'h0100, 13'h0200, 1'b1, 1'b0, 32'h55AA_55AA, 32'h0, 32'hFFFF_FFFF, 32'h0});
        step();
        clr_all();
        set_req(1, 1'b0, 13'h0100, 32'h0, 32'h0);
        #1;
        check("cf_r1_ready", {156'b0, req_ready}, 160'h2);
        check("cf_r2_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b0100, 32'h0, 32'h0BAD_F00D, 32'h0, 32'h0});
        step();
        clr_all();
        #1;
        check("cf_r1_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b0010, 32'h0, 32'h0, 32'h55AA_55AA, 32'h0});

        // Same-address dual read by 1 and 2
        set_req(3, 1'b1, 13'h0005, 32'h600D_CAFE, 32'hFFFF_FFFF);
        step();
        clr_all();
        set_req(1, 1'b0, 13'h0005, 32'h0, 32'h0);
        set_req(2, 1'b0, 13'h0005, 32'h0, 32'h0);
        #1;
        check("dual_ready", {156'b0, req_ready}, 160'h6);
        check("dual_addr", {134'b0, ram_addr_a, ram_addr_b}, {134'b0, 13'h5, 13'h5});
        step();
        clr_all();
        #1;
        check("dual_rsp", {28'b0, rsp_valid, rsp_data},
              {28'b0, 4'b0110, 32'h0, 32'h600D_CAFE, 32'h600D_CAFE, 32'h0});
        check("final_idle_ram", ram_outs(), 160'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
